spi_tx_serializer: RTL
======================

SPI_TX_SERIALIZER -- requirements
Module: spi_tx_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, number of data bits per frame (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: load  input  1  request to capture parallel_in and start a frame.
REQ-005 SHALL have port: parallel_in  input  WIDTH  frame data, MSB transmitted first.
REQ-006 SHALL have port: enable  input  1  shift enable; when low the frame is frozen.
REQ-007 SHALL have port: abort  input  1  synchronous frame cancel.
REQ-008 SHALL have port: serial_out  output  1  registered serial data.
REQ-009 SHALL have port: busy  output  1  registered; high while a frame is in progress.
REQ-010 SHALL have port: EOT  output  1  registered one-cycle end-of-transmission pulse.
REQ-011 SHALL have port: load_err  output  1  registered one-cycle pulse; load rejected because busy.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and SHIFT; busy SHALL equal (state == SHIFT).
REQ-013 SHALL hold a WIDTH-bit shift register and a bit counter sized ceil(log2(WIDTH)) bits.
REQ-014 In IDLE with load=1 and abort=0, SHALL on the edge: serial_out <= parallel_in[WIDTH-1], shreg <= parallel_in shifted left by 1 (zero fill), cnt <= WIDTH-1, state <= SHIFT.
REQ-015 Load capture SHALL NOT depend on enable.
REQ-016 In SHIFT with enable=1 and cnt != 0, SHALL on the edge: serial_out <= shreg[WIDTH-1], shreg shifts left 1, cnt decrements by 1.
REQ-017 In SHIFT with enable=1 and cnt == 0, SHALL on the edge: state <= IDLE, EOT <= 1, serial_out <= 0.
REQ-018 In SHIFT with enable=0, SHALL hold state, shreg, cnt, and serial_out unchanged; no EOT.
REQ-019 Timing with enable held high: bit WIDTH-1-k SHALL be on serial_out for exactly one cycle, from edge k to edge k+1 after the load edge (edge 0), k = 0..WIDTH-1.
REQ-020 Timing with enable held high: EOT SHALL be high for the single cycle following edge WIDTH; busy SHALL be high from edge 0 to edge WIDTH.
REQ-021 EOT SHALL be 0 in every cycle not covered by REQ-017.
REQ-022 load=1 while in SHIFT SHALL be ignored (frame data unaffected) and SHALL pulse load_err for one cycle.
REQ-023 load_err SHALL be 0 in every cycle not covered by REQ-022.
REQ-024 abort=1 on an edge SHALL force state <= IDLE, serial_out <= 0, cnt <= 0, shreg <= 0, EOT <= 0, load_err <= 0, regardless of enable or load.
REQ-025 abort SHALL take priority over load and over the final-bit transition.
REQ-026 In IDLE without load, serial_out SHALL be 0 and all registers SHALL hold.
REQ-027 Back-to-back frames: load SHALL be accepted in the cycle where EOT is high, because state is IDLE in that cycle; a minimum gap of one cycle between frames results.
REQ-028 cnt SHALL never wrap below 0; the cnt == 0 condition SHALL always exit SHIFT.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, set state=IDLE, shreg=0, cnt=0, serial_out=0, busy=0, EOT=0, load_err=0.
REQ-030 Reset asserted mid-frame SHALL discard the frame with no EOT; after release the block SHALL be in IDLE and accept the next load.
REQ-031 Reset release SHALL take effect at the first rising edge after rst_n rises; no output changes until then.

Verification
REQ-032 WIDTH=8, enable=1, load pulse with parallel_in=0xA5 -> serial_out 1,0,1,0,0,1,0,1 on consecutive cycles after the load edge; EOT high exactly one cycle after the last bit; busy high for 8 cycles.
REQ-033 0x3C loaded, enable dropped low for 3 cycles after bit 5 -> serial_out holds bit 5 value (1) for 4 cycles total, then sequence resumes; EOT delayed by 3 cycles.
REQ-034 0xFF loaded, load pulsed again with 0x00 at bit 3 -> frame continues as all ones, load_err one-cycle pulse, no restart.
REQ-035 0x81 loaded, abort asserted after bit 6 -> serial_out=0, busy=0 next cycle, no EOT; following load of 0x55 transmits correctly.
REQ-036 rst_n pulled low asynchronously mid-frame (between edges) -> all outputs 0 immediately; then a load in the EOT cycle of a new 0xC3 frame followed by 0x0F -> both frames correct with a one-cycle gap.

Source files
------------

// File: rtl/spi_tx_serializer.sv
// MSB-first SPI transmit serializer: a parallel load starts a frame, enable paces the
// shifting, and abort or reset cancels the frame. EOT and load_err are one-cycle pulses.
module spi_tx_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             enable,
  input  logic             abort,
  output logic             serial_out,
  output logic             busy,
  output logic             EOT,
  output logic             load_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             eot_q, eot_d;
  logic             lerr_q, lerr_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    so_d    = so_q;
    eot_d   = 1'b0;
    lerr_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      so_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            // The first bit goes out on the load edge, so the register keeps only the remainder.
            so_d    = parallel_in[WIDTH-1];
            shreg_d = {parallel_in[WIDTH-2:0], 1'b0};
            cnt_d   = CW'(WIDTH - 1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          lerr_d = load;
          if (enable) begin
            if (cnt_q == '0) begin
              state_d = IDLE;
              eot_d   = 1'b1;
              so_d    = 1'b0;
            end else begin
              so_d    = shreg_q[WIDTH-1];
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
              cnt_d   = cnt_q - CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      eot_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      eot_q   <= eot_d;
      lerr_q  <= lerr_d;
    end
  end

  assign serial_out = so_q;
  assign busy       = (state_q == SHIFT);
  assign EOT        = eot_q;
  assign load_err   = lerr_q;

endmodule
